// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator running on the system clock. One pixel
// advance per detected rising edge of the (sampled, not clocked) divider output.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       clk_div,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       p_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FP + V_SYNC);

  function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic       s1_q, s2_q, s3_q;
  logic       adv;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       p_tick_q, p_tick_d, frame_start_q, frame_start_d;

  // s1 resolves metastability; s2/s3 form the rising-edge detector
  assign adv = s2_q & ~s3_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= clk_div;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Outputs decode the next coordinates so they stay aligned with the counters
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    p_tick_d      = 1'b0;
    frame_start_d = 1'b0;
    if (adv) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      hsync_d       = ~in_window(x_d, HS_START, HS_END);
      vsync_d       = ~in_window(y_d, VS_START, VS_END);
      video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
      p_tick_d      = 1'b1;
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      p_tick_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      p_tick_q      <= p_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign p_tick      = p_tick_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken-timing
// instance share stimulus and are compared every cycle to an update-count model.
module tb_vga_sync_gen;

  localparam int SHD = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVD = 12, SVF = 2, SVS = 2, SVB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clk_div;
  logic       hs_d, vs_d, von_d, pt_d, fs_d;
  logic [9:0] px_d, py_d;
  logic       hs_s, vs_s, von_s, pt_s, fs_s;
  logic [9:0] px_s, py_s;

  vga_sync_gen dut_d (
    .clk_in(clk), .reset(rst_n), .clk_div(clk_div),
    .hsync(hs_d), .vsync(vs_d), .video_on(von_d),
    .pixel_x(px_d), .pixel_y(py_d), .p_tick(pt_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_DISPLAY(SHD), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_DISPLAY(SVD), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) dut_s (
    .clk_in(clk), .reset(rst_n), .clk_div(clk_div),
    .hsync(hs_s), .vsync(vs_s), .video_on(von_s),
    .pixel_x(px_s), .pixel_y(py_s), .p_tick(pt_s), .frame_start(fs_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: count of updates since reset; an update happens on the edge two
  // edges after the edge that first samples clk_div high.
  longint   n = 0;
  logic [2:0] hist = 3'b000;
  bit       tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n    = 0;
      hist = 3'b000;
      tick = 1'b0;
    end else begin
      tick = hist[1] & ~hist[2];
      if (tick) n++;
      hist = {hist[1:0], clk_div};
    end
  end

  task automatic check_dut(input string tag,
                           input int hd, input int hf, input int hsw, input int hb,
                           input int vd, input int vf, input int vsw, input int vb,
                           input logic hs, input logic vs, input logic von,
                           input logic [9:0] px, input logic [9:0] py,
                           input logic pt, input logic fs);
    longint ht, vt, fr, idx, x, y;
    ht  = hd + hf + hsw + hb;
    vt  = vd + vf + vsw + vb;
    fr  = ht * vt;
    idx = (n + fr - 1) % fr;
    x   = idx % ht;
    y   = idx / ht;
    chk({tag, ".pixel_x"}, px, x);
    chk({tag, ".pixel_y"}, py, y);
    chk({tag, ".hsync"}, hs, !(x >= hd + hf && x < hd + hf + hsw));
    chk({tag, ".vsync"}, vs, !(y >= vd + vf && y < vd + vf + vsw));
    chk({tag, ".video_on"}, von, (x < hd) && (y < vd));
    chk({tag, ".p_tick"}, pt, tick);
    chk({tag, ".frame_start"}, fs, tick && x == 0 && y == 0);
  endtask

  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      check_dut("dflt", 640, 16, 96, 48, 480, 10, 2, 33,
                hs_d, vs_d, von_d, px_d, py_d, pt_d, fs_d);
      check_dut("small", SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB,
                hs_s, vs_s, von_s, px_s, py_s, pt_s, fs_s);
    end
  end

  // Frame statistics on the small instance
  int  cyc = 0;
  always @(posedge clk) cyc++;
  bit  mon_en = 1'b0;
  int  fs_seen = 0, last_fs = 0, fs_gap = 0, vlow_cnt = 0, von_cnt_s = 0;
  always @(negedge clk) begin
    if (mon_en && pt_s) begin
      if (fs_s) begin
        if (fs_seen == 2) fs_gap = cyc - last_fs;
        last_fs = cyc;
        fs_seen++;
      end
      if (fs_seen == 2) begin
        if (!vs_s) vlow_cnt++;
        if (von_s) von_cnt_s++;
      end
    end
  end

  int ph = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic nom_step();
    step();
    ph = (ph + 1) % 4;
    clk_div = (ph >= 2);
  endtask

  task automatic nom_until(input int x, input int y, input int budget, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      nom_step();
      if (pt_d && px_d == 10'(x) && py_d == 10'(y)) found = 1'b1;
    end
    chk({name, ".reached"}, found, 1);
  endtask

  task automatic check_reset_literals(input string name);
    chk({name, ".x"}, px_d, 799);
    chk({name, ".y"}, py_d, 524);
    chk({name, ".hsync"}, hs_d, 1);
    chk({name, ".vsync"}, vs_d, 1);
    chk({name, ".video_on"}, von_d, 0);
    chk({name, ".p_tick"}, pt_d, 0);
    chk({name, ".frame_start"}, fs_d, 0);
    chk({name, ".small_x"}, px_s, 31);
    chk({name, ".small_y"}, py_s, 18);
  endtask

  initial begin
    int hl, vc, prev_x, ticks, bad, len;
    bit lvl;
    rst_n   = 1'b0;
    clk_div = 1'b0;
    repeat (3) step();
    check_reset_literals("reset");
    rst_n    = 1'b1;
    check_en = 1'b1;
    mon_en   = 1'b1;

    // first update lands on (0,0)
    nom_until(0, 0, 20, "first_update");
    chk("first.frame_start", fs_d, 1);
    chk("first.video_on", von_d, 1);
    chk("first.hsync", hs_d, 1);
    chk("first.vsync", vs_d, 1);

    // one full line on the default instance
    hl = 0; vc = 1; prev_x = 0;
    for (int i = 0; i < 4000; i++) begin
      nom_step();
      if (pt_d) begin
        if (px_d == 10'd0 && py_d == 10'd1) break;
        if (!hs_d) begin
          if (hl == 0) chk("line.first_hs_low_x", px_d, 656);
          hl++;
        end
        if (von_d) vc++;
        prev_x = int'(px_d);
      end
    end
    chk("line.hsync_low_updates", hl, 96);
    chk("line.video_on_updates", vc, 640);
    chk("line.wrap_from_x", prev_x, 799);
    chk("line.wrap_to_y", py_d, 1);

    nom_until(300, 10, 40000, "goto_300_10");
    chk("frame.count_seen", fs_seen >= 3, 1);
    chk("frame.fs_gap_cycles", fs_gap, 32 * 19 * 4);
    chk("frame.vsync_low_updates", vlow_cnt, 2 * 32);
    chk("frame.video_on_updates", von_cnt_s, 16 * 12);

    // stall: clk_div held low
    clk_div = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (pt_d || px_d != 10'd300 || py_d != 10'd10 || hs_d != 1'b1 || von_d != 1'b1) bad++;
    end
    chk("stall_low.changes", bad, 0);
    clk_div = 1'b1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pt_d) ticks++;
    end
    chk("resume.ticks", ticks, 1);
    chk("resume.x", px_d, 301);
    chk("resume.y", py_d, 10);

    // randomized clk_div segments, checked by the per-cycle compare
    lvl = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      len = int'($urandom_range(1, 6));
      if ($urandom_range(0, 9) == 0) len = len + 40;
      lvl = ~lvl;
      clk_div = lvl;
      repeat (len) step();
    end

    // mid-frame reset between clock edges
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_literals("midreset");
    clk_div = 1'b0;
    ph = 0;
    repeat (3) step();
    rst_n = 1'b1;
    nom_until(0, 0, 20, "after_midreset");
    chk("after_midreset.frame_start", fs_d, 1);

    // clk_div high through reset release
    rst_n   = 1'b0;
    clk_div = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pt_d) ticks++;
    end
    chk("high_release.ticks", ticks, 1);
    chk("high_release.x", px_d, 0);
    chk("high_release.y", py_d, 0);
    clk_div = 1'b0;
    repeat (5) step();
    clk_div = 1'b1;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pt_d) ticks++;
    end
    chk("high_release.next_ticks", ticks, 1);
    chk("high_release.next_x", px_d, 1);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480 @ 60 Hz VGA timing: horizontal/vertical sync, an active-video flag and the current pixel coordinates. It sits directly downstream of the 25 MHz clock divider and consumes that divider's output as a level signal. The divider output is not used as a clock. The block runs on the 100 MHz system clock and advances one pixel per detected rising edge of the divider output. Its outputs drive the pixel generator and the VGA connector pins.

## Interface
Parameters:
- H_DISPLAY, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync pulse width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_DISPLAY, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync pulse width, in lines
- V_BP, 33: vertical back porch, in lines

Ports:
- clk_in  input  1  100 MHz system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- clk_div  input  1  25 MHz square wave from the divider; asynchronous to this block's logic, sampled only
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- video_on  output  1  high while the current pixel is inside the visible area
- pixel_x  output  10  current column, 0..H_TOTAL-1
- pixel_y  output  10  current row, 0..V_TOTAL-1
- p_tick  output  1  one-cycle pulse in the first clk_in cycle of each new pixel
- frame_start  output  1  one-cycle pulse, coincident with p_tick, when the coordinates become (0,0)

## Operation
- Derived constants: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Both totals must be ≤1024. Counters are 10-bit unsigned.
- Edge detect:
  - clk_div passes through three flops, s1→s2→s3, all reset to 0.
  - adv = s2 & ~s3.
  - Exactly one adv per clk_div rising edge; falling edges are ignored.
- On each clk_in edge with adv=1:
  - pixel_x increments. At H_TOTAL-1 it wraps to 0.
  - On that wrap, pixel_y increments. At V_TOTAL-1 it wraps to 0.
- All outputs are registers, updated on the same edge as the counters, and always decode the new coordinates:
  - hsync = 0 iff H_DISPLAY+H_FP ≤ x < H_DISPLAY+H_FP+H_SYNC, i.e. 656..751.
  - vsync = 0 iff V_DISPLAY+V_FP ≤ y < V_DISPLAY+V_FP+V_SYNC, i.e. 490..491.
  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
  - p_tick = 1 on every update edge, 0 otherwise.
  - frame_start = 1 iff the new coordinates are (0,0).
- With no adv, all outputs hold, except p_tick and frame_start, which return to 0.

## Timing
- Reset values (immediate on reset low, no clock needed):
  - pixel_x=799, pixel_y=524
  - hsync=1, vsync=1, video_on=0
  - p_tick=0, frame_start=0
  - s1=s2=s3=0
- The first update after reset lands on (0,0) with frame_start=1.
- Latency: if clk_div rises between clk_in edges k-1 and k, the outputs change at edge k+2.
- Nominal rate: one update every 4 clk_in cycles. One line = 800 updates; one frame = 420000 updates = 1,680,000 clk_in cycles.
- clk_div stuck high or low: counters freeze, sync levels hold, and no p_tick is produced. Counting resumes on the next rising edge with no skipped or repeated coordinate.
- clk_div high at reset release: it produces exactly one update, two clk_in edges after s1 first captures the 1.
- Reset mid-frame: the block aborts immediately to the reset values. No partial sync pulse is extended.
- Simultaneous x and y wrap at (799,524): the block goes to (0,0) in a single update.

## Test plan
- Reset, then drive clk_div with period 4 clk_in cycles → the first update gives pixel (0,0) with frame_start=1, p_tick=1, video_on=1, hsync=1, vsync=1.
- Run one line from (0,0) → hsync is low for exactly 96 updates, covering pixel_x 656..751. At (799,0) the next update gives (0,1). video_on is high for 640 updates.
- Run a full frame → frame_start pulses are 1,680,000 clk_in cycles apart. vsync is low for exactly 1600 updates, (0,490) through (799,491). video_on totals 307200 updates.
- At (300,10), hold clk_div low for 100 cycles → no p_tick, and all outputs are stable. The next rising edge gives (301,10).
- At (300,200), pull reset low between clock edges → outputs go to the reset values immediately. After release plus the first clk_div edge, coordinates are (0,0) with frame_start=1.
- Hold clk_div high through reset release → exactly one update to (0,0), then none until clk_div falls and rises again.
